// File: rtl/thunderbolt_tsip_decoder_pkg.sv
// thunderbolt_tsip_decoder_pkg: TSIP framing constants, field offsets, FSM states and time record
package thunderbolt_tsip_decoder_pkg;
  localparam logic [7:0] TSIP_DLE         = 8'h10;
  localparam logic [7:0] TSIP_ETX         = 8'h03;
  localparam logic [7:0] TSIP_ID_TIMING   = 8'h8F;
  localparam logic [7:0] TSIP_SUB_PRIMARY = 8'hAB;
  localparam logic [4:0] TSIP_AB_LEN      = 5'd16;
  localparam logic [4:0] TSIP_OFF_SEC     = 5'd9;
  localparam logic [4:0] TSIP_OFF_MIN     = 5'd10;
  localparam logic [4:0] TSIP_OFF_HOUR    = 5'd11;
  localparam logic [4:0] TSIP_OFF_DAY     = 5'd12;
  localparam logic [4:0] TSIP_OFF_MONTH   = 5'd13;
  localparam logic [4:0] TSIP_OFF_YEAR_H  = 5'd14;
  localparam logic [4:0] TSIP_OFF_YEAR_L  = 5'd15;
  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DATA, S_SKIP} state_e;
  typedef struct packed {
    logic [7:0] year_h;
    logic [7:0] year_l;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minutes;
    logic [7:0] seconds;
  } tsip_time_t;
  // A DLE-prefixed ID byte selects the next state: only the timing ID is worth parsing.
  function automatic state_e id_state(input logic [7:0] id);
    return (id == TSIP_ID_TIMING) ? S_SUB : S_SKIP;
  endfunction
endpackage

// File: rtl/tsip_destuffer.sv
// tsip_destuffer: turns the raw TSIP byte stream into start/payload/end/frame-error strobes
//   i_clk, i_rst       clock, synchronous active-high reset (also used to flush on timeout)
//   i_data, i_valid    raw received byte and its strobe
//   o_data             byte carried by o_sop (ID) or o_byte (payload)
//   o_sop              DLE + ID seen
//   o_byte             destuffed payload byte
//   o_eop              DLE ETX seen
//   o_ferr             DLE + ID seen while a packet was still open
module tsip_destuffer
  import thunderbolt_tsip_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_sop,
  output logic       o_byte,
  output logic       o_eop,
  output logic       o_ferr
);
  logic dle_q, dle_d, in_pkt_q, in_pkt_d, is_dle, is_etx;
  // Strobes are combinational so the decoder acts on the same edge that samples the byte.
  always_comb begin
    is_dle   = i_data == TSIP_DLE;
    is_etx   = i_data == TSIP_ETX;
    o_data   = i_data;
    o_byte   = i_valid && (dle_q ? is_dle : !is_dle);
    o_eop    = i_valid && dle_q && is_etx;
    o_sop    = i_valid && dle_q && !is_dle && !is_etx;
    o_ferr   = o_sop && in_pkt_q;
    dle_d    = i_valid ? (!dle_q && is_dle) : dle_q;
    in_pkt_d = o_sop ? 1'b1 : o_eop ? 1'b0 : in_pkt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dle_q    <= 1'b0;
      in_pkt_q <= 1'b0;
    end else begin
      dle_q    <= dle_d;
      in_pkt_q <= in_pkt_d;
    end
  end
endmodule

// File: rtl/thunderbolt_tsip_decoder.sv
// thunderbolt_tsip_decoder: extracts UTC date/time from TSIP primary-timing packets 0x8F-AB
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rx_data, i_rx_valid   UART receive byte and one-cycle strobe
//   o_thunder_*             last committed date/time fields
//   o_time_valid            one-cycle pulse when a new time is committed
//   o_pkt_err               one-cycle pulse on a malformed or timed-out 0x8F-AB packet
module thunderbolt_tsip_decoder
  import thunderbolt_tsip_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_thunder_year_h,
  output logic [7:0] o_thunder_year_l,
  output logic [7:0] o_thunder_month,
  output logic [7:0] o_thunder_day,
  output logic [7:0] o_thunder_hour,
  output logic [7:0] o_thunder_minutes,
  output logic [7:0] o_thunder_seconds,
  output logic       o_time_valid,
  output logic       o_pkt_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  tsip_time_t      shd_q, shd_d, out_q, out_d;
  logic            valid_q, valid_d, err_q, err_d;
  logic            timeout, commit_ok;
  logic [7:0]      sd;
  logic            sop, pbyte, eop, ferr;
  // The destuffer is flushed on timeout too, so a dangling DLE cannot leak into the next packet.
  tsip_destuffer u_destuffer (
    .i_clk   (i_clk),
    .i_rst   (i_rst || timeout),
    .i_data  (i_rx_data),
    .i_valid (i_rx_valid),
    .o_data  (sd),
    .o_sop   (sop),
    .o_byte  (pbyte),
    .o_eop   (eop),
    .o_ferr  (ferr)
  );
  assign timeout   = state_q != S_IDLE && !i_rx_valid && tmo_q == TMAX;
  assign commit_ok = cnt_q == TSIP_AB_LEN && !ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    shd_d   = shd_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (i_rx_valid || state_q == S_IDLE) ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + 1'b1);
    if (timeout) begin
      state_d = S_IDLE;
      err_d   = state_q == S_DATA;
    end else begin
      case (state_q)
        S_IDLE: state_d = sop ? id_state(sd) : S_IDLE;
        S_SUB: begin
          if (pbyte) begin
            state_d = (sd == TSIP_SUB_PRIMARY) ? S_DATA : S_SKIP;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else if (sop) state_d = id_state(sd);
          else if (eop) state_d = S_IDLE;
        end
        S_DATA: begin
          if (pbyte) begin
            // Past the expected length, stop counting and remember the overrun instead.
            ovf_d         = ovf_q || cnt_q == TSIP_AB_LEN;
            cnt_d         = (cnt_q == TSIP_AB_LEN) ? cnt_q : cnt_q + 1'b1;
            shd_d.seconds = (cnt_q == TSIP_OFF_SEC)    ? sd : shd_q.seconds;
            shd_d.minutes = (cnt_q == TSIP_OFF_MIN)    ? sd : shd_q.minutes;
            shd_d.hour    = (cnt_q == TSIP_OFF_HOUR)   ? sd : shd_q.hour;
            shd_d.day     = (cnt_q == TSIP_OFF_DAY)    ? sd : shd_q.day;
            shd_d.month   = (cnt_q == TSIP_OFF_MONTH)  ? sd : shd_q.month;
            shd_d.year_h  = (cnt_q == TSIP_OFF_YEAR_H) ? sd : shd_q.year_h;
            shd_d.year_l  = (cnt_q == TSIP_OFF_YEAR_L) ? sd : shd_q.year_l;
          end
          if (eop) begin
            state_d = S_IDLE;
            valid_d = commit_ok;
            err_d   = !commit_ok;
            out_d   = commit_ok ? shd_q : out_q;
          end
          // DLE + other inside a packet aborts it; the byte is decoded as a fresh ID.
          if (sop) begin
            state_d = id_state(sd);
            err_d   = ferr;
          end
        end
        default: state_d = eop ? S_IDLE : sop ? id_state(sd) : S_SKIP;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      shd_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      shd_q   <= shd_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign o_thunder_year_h  = out_q.year_h;
  assign o_thunder_year_l  = out_q.year_l;
  assign o_thunder_month   = out_q.month;
  assign o_thunder_day     = out_q.day;
  assign o_thunder_hour    = out_q.hour;
  assign o_thunder_minutes = out_q.minutes;
  assign o_thunder_seconds = out_q.seconds;
  assign o_time_valid      = valid_q;
  assign o_pkt_err         = err_q;
endmodule

// File: tb/tb_thunderbolt_tsip_decoder.sv
// tb_thunderbolt_tsip_decoder: directed scoreboard bench for the TSIP 0x8F-AB time decoder
module tb_thunderbolt_tsip_decoder;
  localparam int TMO = 100;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] yh, yl, mo, dy, hr, mi, se;
  logic       tv, pe;
  typedef struct {
    logic [55:0] t;
    logic        v;
    logic        e;
  } exp_t;
  exp_t        sb[$];
  exp_t        ex;
  logic [7:0]  tx[$];
  logic [55:0] cur = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  wire  [55:0] obs_t = {yh, yl, mo, dy, hr, mi, se};

  thunderbolt_tsip_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .o_thunder_year_h  (yh),
    .o_thunder_year_l  (yl),
    .o_thunder_month   (mo),
    .o_thunder_day     (dy),
    .o_thunder_hour    (hr),
    .o_thunder_minutes (mi),
    .o_thunder_seconds (se),
    .o_time_valid      (tv),
    .o_pkt_err         (pe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every pulse must match the oldest expected event, and the outputs must show that event's time.
  always @(negedge clk) begin
    if (!rst && (tv || pe)) begin
      if (sb.size() == 0) check("unexpected_pulse", {62'd0, tv, pe}, 64'd0);
      else begin
        ex = sb.pop_front();
        check("pulse_kind", {62'd0, tv, pe}, {62'd0, ex.v, ex.e});
        check("pulse_time", {8'd0, obs_t}, {8'd0, ex.t});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_tx();
    foreach (tx[i]) send_byte(tx[i]);
    tx.delete();
  endtask

  task automatic flush();
    send_tx();
    repeat (4) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    tx.push_back(b);
    if (b == 8'h10) tx.push_back(b);
  endtask

  task automatic put_range(input logic [55:0] t, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      case (i)
        9:       put(t[7:0]);
        10:      put(t[15:8]);
        11:      put(t[23:16]);
        12:      put(t[31:24]);
        13:      put(t[39:32]);
        14:      put(t[55:48]);
        15:      put(t[47:40]);
        default: put(i < 9 ? 8'(i * 3) : 8'h55);
      endcase
    end
  endtask

  task automatic hdr(input logic [7:0] sub);
    tx.push_back(8'h10);
    tx.push_back(8'h8F);
    tx.push_back(sub);
  endtask

  task automatic tail();
    tx.push_back(8'h10);
    tx.push_back(8'h03);
  endtask

  task automatic good_pkt(input logic [55:0] t);
    hdr(8'hAB);
    put_range(t, 0, 15);
    tail();
    sb.push_back('{t, 1'b1, 1'b0});
    cur = t;
    flush();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_time", {8'd0, obs_t}, 64'd0);
    check("rst_valid", {63'd0, tv}, 64'd0);
    check("rst_err", {63'd0, pe}, 64'd0);
    // 1: basic packet, year 0x07E8 March 15 12:34:56
    good_pkt(56'h07E8_030F_0C22_38);
    check("t1_time", {8'd0, obs_t}, 64'h0007E8030F0C2238);
    check("t1_sb", 64'(sb.size()), 64'd0);
    // 2: seconds = 0x10 travels stuffed
    good_pkt(56'h07E8_030F_0C22_10);
    check("t2_time", {8'd0, obs_t}, 64'h0007E8030F0C2210);
    // 3: other sub-ID and other packet ID are ignored
    hdr(8'hAC);
    for (int i = 0; i < 20; i++) put(8'h21);
    tail();
    tx.push_back(8'h10);
    tx.push_back(8'h47);
    for (int i = 0; i < 5; i++) put(8'h8F);
    tail();
    flush();
    check("t3_hold", {8'd0, obs_t}, {8'd0, cur});
    check("t3_sb", 64'(sb.size()), 64'd0);
    // 4: short and long payloads
    hdr(8'hAB);
    put_range(56'h07E9_0101_0000_00, 0, 14);
    tail();
    sb.push_back('{cur, 1'b0, 1'b1});
    flush();
    check("t4_short_hold", {8'd0, obs_t}, {8'd0, cur});
    hdr(8'hAB);
    put_range(56'h07E9_0101_0000_00, 0, 16);
    tail();
    sb.push_back('{cur, 1'b0, 1'b1});
    flush();
    check("t4_long_hold", {8'd0, obs_t}, {8'd0, cur});
    check("t4_sb", 64'(sb.size()), 64'd0);
    // DLE + new ID mid-payload aborts, then that ID starts a valid packet
    hdr(8'hAB);
    put_range(56'h0, 0, 3);
    sb.push_back('{cur, 1'b0, 1'b1});
    good_pkt(56'h07EA_0C1F_173B_3C);
    check("ferr_then_good", {8'd0, obs_t}, 64'h0007EA0C1F173B3C);
    // 5: stall after payload byte 5 times out
    hdr(8'hAB);
    put_range(56'h0, 0, 5);
    sb.push_back('{cur, 1'b0, 1'b1});
    send_tx();
    repeat (150) @(negedge clk);
    check("t5_timeout_sb", 64'(sb.size()), 64'd0);
    check("t5_hold", {8'd0, obs_t}, {8'd0, cur});
    good_pkt(56'h0801_0203_0405_06);
    check("t5_after", {8'd0, obs_t}, 64'h0008010203040506);
    // 6: reset in the middle of a packet
    hdr(8'hAB);
    put_range(56'h07E8_0707_0707_07, 0, 11);
    send_tx();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur = '0;
    check("t6_rst_time", {8'd0, obs_t}, 64'd0);
    put_range(56'h07E8_0707_0707_07, 12, 15);
    tail();
    flush();
    check("t6_rest_ignored", {8'd0, obs_t}, 64'd0);
    check("t6_sb", 64'(sb.size()), 64'd0);
    good_pkt(56'h07E8_0B1E_1718_19);
    check("t6_after", {8'd0, obs_t}, 64'h0007E80B1E171819);
    check("sb_final", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
